// File: rtl/tdm_lane_mux.sv
// -----------------------------------------------------------------------------
// tdm_lane_mux
//   N:1 time-division lane multiplexer for the phy_tx path. All NUM_CH lanes
//   are captured once per frame into shadow registers. The shadow copy is then
//   emitted one lane per cycle in fixed order 0..NUM_CH-1. Invalid or masked
//   lanes are emitted as IDLE_SYM with valid_out low. frame_start marks slot 0
//   for the downstream serializer.
//
//   A lane sampled at capture edge E appears on data_out at edge E+1+k, where
//   k is the lane index. The first capture happens at edge NUM_CH after reset
//   release, so the first frame after reset is idle.
//
// Optional feature:
//   `define TDM_LANE_MUX_PARITY_EN adds parity_out. It holds the even-parity
//   bit (^data_out) while valid_out is high, and 0 otherwise.
//
// Ports:
//   clk_f       single fast clock, NUM_CH x lane word rate
//   reset_L     asynchronous active-low reset
//   en          advance enable; 0 freezes the slot sequence and idles output
//   ch_mask     per-lane disable (1 = disabled), sampled with lane data
//   data_in     lane i at [i*DATA_W +: DATA_W]
//   valid_in    per-lane valid
//   data_out    registered multiplexed word
//   valid_out   data_out carries lane data
//   ch_id       lane index of the current data_out
//   frame_start high for slot 0 on an advancing edge
//   parity_out  (optional) parity of data_out when valid_out is high
// -----------------------------------------------------------------------------
module tdm_lane_mux #(
    parameter int                   NUM_CH   = 4,
    parameter int                   DATA_W   = 8,
    parameter logic [DATA_W-1:0]    IDLE_SYM = DATA_W'(8'hBC),
    localparam int                  CNT_W    = $clog2(NUM_CH)
) (
    input  logic                     clk_f,
    input  logic                     reset_L,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        valid_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    output logic [CNT_W-1:0]         ch_id,
    output logic                     frame_start
`ifdef TDM_LANE_MUX_PARITY_EN
   ,output logic                     parity_out
`endif
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CH - 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sh_data [NUM_CH];
    logic [NUM_CH-1:0] sh_valid;

    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              last_slot;

    // Slot selection from the pre-capture shadow copy.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path can leave it unassigned and infer a latch.
        sel_valid = 1'b0;
        sel_data  = IDLE_SYM;
        last_slot = 1'b0;

        sel_valid = sh_valid[cnt];
        last_slot = (cnt == LAST_SLOT);
        if (sel_valid) begin
            sel_data = sh_data[cnt];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. The output
    // stage therefore reads the shadow value from before this edge's capture,
    // which is what lets lane NUM_CH-1 be read and overwritten on one edge.
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            cnt         <= '0;
            // NOTE: the shadow array is reset explicitly. The first frame after
            // reset reads it before any capture, and it must read as idle
            // rather than stale power-up contents.
            for (int i = 0; i < NUM_CH; i++) begin
                sh_data[i] <= IDLE_SYM;
            end
            sh_valid    <= '0;
            data_out    <= IDLE_SYM;
            valid_out   <= 1'b0;
            ch_id       <= '0;
            frame_start <= 1'b0;
        end else if (en) begin
            cnt         <= last_slot ? '0 : cnt + CNT_W'(1);
            data_out    <= sel_data;
            valid_out   <= sel_valid;
            ch_id       <= cnt;
            frame_start <= (cnt == '0);
            if (last_slot) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    sh_data[i] <= data_in[i*DATA_W +: DATA_W];
                end
                sh_valid <= valid_in & ~ch_mask;
            end
        end else begin
            // Stalled: the sequence and ch_id hold, and the output idles. A
            // capture due at the last slot waits until en returns.
            data_out    <= IDLE_SYM;
            valid_out   <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef TDM_LANE_MUX_PARITY_EN
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            parity_out <= 1'b0;
        end else begin
            parity_out <= en & sel_valid & (^sel_data);
        end
    end
`endif

endmodule

// File: tb/tb_tdm_lane_mux.sv
// -----------------------------------------------------------------------------
// tb_tdm_lane_mux
//   Self-checking bench for tdm_lane_mux (NUM_CH=4, DATA_W=8). The reference
//   model is a queue of pending output slots. Each advancing edge pops one
//   slot, and popping the last slot of a frame pushes the frame captured from
//   the current inputs.
// -----------------------------------------------------------------------------
module tb_tdm_lane_mux;

    localparam int          NCH  = 4;
    localparam int          DW   = 8;
    localparam int          CW   = $clog2(NCH);
    localparam logic [7:0]  IDLE = 8'hBC;

    logic                clk_f = 1'b0;
    logic                reset_L;
    logic                en;
    logic [NCH-1:0]      ch_mask;
    logic [NCH*DW-1:0]   data_in;
    logic [NCH-1:0]      valid_in;
    logic [DW-1:0]       data_out;
    logic                valid_out;
    logic [CW-1:0]       ch_id;
    logic                frame_start;
`ifdef TDM_LANE_MUX_PARITY_EN
    logic                parity_out;
`endif

    always #5 clk_f = ~clk_f;

    tdm_lane_mux #(.NUM_CH(NCH), .DATA_W(DW)) dut (
        .clk_f       (clk_f),
        .reset_L     (reset_L),
        .en          (en),
        .ch_mask     (ch_mask),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ch_id       (ch_id),
        .frame_start (frame_start)
`ifdef TDM_LANE_MUX_PARITY_EN
       ,.parity_out  (parity_out)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] d;
        bit         v;
        int         ch;
    } slot_t;

    slot_t q[$];
    int    held_ch;

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < NCH; i++) q.push_back('{d: IDLE, v: 1'b0, ch: i});
        held_ch = 0;
    endfunction

    task automatic check_idle_reset(input string tag);
        check({tag, "_data"},  data_out,    IDLE);
        check({tag, "_valid"}, valid_out,   0);
        check({tag, "_ch"},    ch_id,       0);
        check({tag, "_fs"},    frame_start, 0);
`ifdef TDM_LANE_MUX_PARITY_EN
        check({tag, "_par"},   parity_out,  0);
`endif
    endtask

    // One clock edge: compute expectation from the inputs present at the
    // edge, then compare 1 ns later.
    task automatic step();
        logic [7:0] e_d;
        bit         e_v;
        int         e_ch;
        bit         e_fs;
        @(posedge clk_f);
        if (en) begin
            slot_t s;
            s    = q.pop_front();
            e_d  = s.v ? s.d : IDLE;
            e_v  = s.v;
            e_ch = s.ch;
            e_fs = (s.ch == 0);
            held_ch = s.ch;
            if (s.ch == NCH - 1) begin
                for (int i = 0; i < NCH; i++) begin
                    bit ok;
                    ok = valid_in[i] && !ch_mask[i];
                    q.push_back('{d: ok ? data_in[i*DW +: DW] : IDLE, v: ok, ch: i});
                end
            end
        end else begin
            e_d  = IDLE;
            e_v  = 1'b0;
            e_ch = held_ch;
            e_fs = 1'b0;
        end
        #1;
        check("data_out",    data_out,    e_d);
        check("valid_out",   valid_out,   e_v);
        check("ch_id",       ch_id,       e_ch);
        check("frame_start", frame_start, e_fs);
`ifdef TDM_LANE_MUX_PARITY_EN
        check("parity_out",  parity_out,  e_v ? ^e_d : 1'b0);
`endif
    endtask

    // Advance until data_out shows lane c, within a bounded number of edges.
    task automatic wait_ch(input int c);
        for (int i = 0; i < 4 * NCH; i++) begin
            if (ch_id == c && en) return;
            step();
        end
        check("wait_ch_timeout", 0, 1);
    endtask

    task automatic set_lanes(input logic [7:0] l0, l1, l2, l3);
        data_in = {l3, l2, l1, l0};
    endtask

    initial begin
        reset_L  = 1'b0;
        en       = 1'b0;
        ch_mask  = '0;
        valid_in = '0;
        data_in  = '0;
        model_reset();
        #12;
        check_idle_reset("reset");

        // Basic frame: one idle frame, then 11 22 33 44.
        en = 1'b1;
        valid_in = 4'b1111;
        set_lanes(8'h11, 8'h22, 8'h33, 8'h44);
        @(negedge clk_f);
        reset_L = 1'b1;
        for (int i = 0; i < 3 * NCH; i++) step();

        // Invalid and masked lanes.
        valid_in = 4'b1011;
        ch_mask  = 4'b1000;
        for (int i = 0; i < 3 * NCH; i++) step();

        // Lane 2 changes mid-frame but is restored before the capture edge.
        valid_in = 4'b1111;
        ch_mask  = 4'b0000;
        wait_ch(0);
        set_lanes(8'h11, 8'h22, 8'h55, 8'h44);
        step();
        set_lanes(8'h11, 8'h22, 8'h33, 8'h44);
        for (int i = 0; i < 3 * NCH; i++) begin
            step();
            check("no_55", data_out == 8'h55, 0);
        end

        // en stall while lane 1 is on the output.
        wait_ch(1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        en = 1'b1;
        for (int i = 0; i < 2 * NCH; i++) step();

        // Async reset mid-frame: outputs clear without a clock edge.
        wait_ch(2);
        #2;
        reset_L = 1'b0;
        #1;
        check_idle_reset("async_rst");
        model_reset();
        @(negedge clk_f);
        reset_L = 1'b1;
        for (int i = 0; i < 3 * NCH; i++) step();

        // Randomized traffic with random stalls and occasional resets.
        for (int n = 0; n < 600; n++) begin
            en       = ($urandom_range(0, 3) != 0);
            data_in  = $urandom;
            valid_in = NCH'($urandom);
            ch_mask  = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset_L = 1'b0;
                #1;
                check_idle_reset("rand_rst");
                model_reset();
                @(negedge clk_f);
                reset_L = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
